// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and the
// LED generator period that the capture side is expected to see.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int PWM_PERIOD = 256;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by a one-flop
// edge detector producing single-cycle rise/fall flags.
module sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of one PWM input in clk cycles, and reports
// a static level when no edge has been seen for TIMEOUT cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             is_static,
    output logic             static_level,
    output logic             valid
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDLE_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state, state_nxt;
    logic             level, rise, fall;
    logic             timeout, period_done;
    logic [CNT_W-1:0] hi_cnt, per_cnt, idle_cnt;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_in),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_nxt   = state;
        timeout     = enable && !rise && !fall && (idle_cnt == IDLE_LAST);
        period_done = enable && (state == LOW) && rise;
        if (!enable || timeout) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = HIGH;
                HIGH:    if (fall) state_nxt = LOW;
                LOW:     if (rise) state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt       <= '0;
            per_cnt      <= '0;
            idle_cnt     <= '0;
            high_cnt     <= '0;
            period_cnt   <= '0;
            is_static    <= 1'b0;
            static_level <= 1'b0;
            valid        <= 1'b0;
        end else if (!enable) begin
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= period_done | timeout;

            // Saturating at TIMEOUT keeps one static report per edge-free interval
            if (rise || fall) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_SAT) begin
                idle_cnt <= idle_cnt + ONE;
            end

            if (timeout) begin
                hi_cnt  <= '0;
                per_cnt <= '0;
            end else begin
                case (state)
                    HIGH: begin
                        per_cnt <= per_cnt + ONE;
                        if (!fall) hi_cnt <= hi_cnt + ONE;
                    end
                    LOW: begin
                        if (rise) begin
                            hi_cnt  <= ONE;
                            per_cnt <= ONE;
                        end else begin
                            per_cnt <= per_cnt + ONE;
                        end
                    end
                    default: begin
                        hi_cnt  <= rise ? ONE : '0;
                        per_cnt <= rise ? ONE : '0;
                    end
                endcase
            end

            if (period_done) begin
                high_cnt   <= hi_cnt;
                period_cnt <= per_cnt;
                is_static  <= 1'b0;
            end else if (timeout) begin
                high_cnt     <= '0;
                period_cnt   <= '0;
                is_static    <= 1'b1;
                static_level <= level;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture: steady PWM, duty change,
// static timeouts, single-cycle pulses, async reset and enable gating.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 4096;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic             clk = 1'b0;
    logic             rst, enable, pwm_in;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             is_static, static_level, valid;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    int unsigned rep_hi[$];
    int unsigned rep_per[$];
    logic        rep_st[$];
    logic        rep_lvl[$];
    int unsigned rep_cyc[$];

    pwm_capture #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .is_static   (is_static),
        .static_level(static_level),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every valid strobe with its results and the clock index it appeared on
    always @(posedge clk) begin
        #1;
        if (valid) begin
            rep_hi.push_back(int'(high_cnt));
            rep_per.push_back(int'(period_cnt));
            rep_st.push_back(is_static);
            rep_lvl.push_back(static_level);
            rep_cyc.push_back(cyc);
        end
    end

    task automatic run(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (high_cnt !== 16'd0)   begin miscompares++; $display("FAIL reset_high_cnt got %0d want 0", high_cnt); end
        vectors++; if (period_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_period_cnt got %0d want 0", period_cnt); end
        vectors++; if (is_static !== 1'b0)   begin miscompares++; $display("FAIL reset_is_static got %b want 0", is_static); end
        vectors++; if (static_level !== 1'b0) begin miscompares++; $display("FAIL reset_static_level got %b want 0", static_level); end
        vectors++; if (valid !== 1'b0)       begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        rst = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_steady();
        int base = rep_hi.size();
        int unsigned t = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) t = cyc;
            run(1'b1, 64);
            run(1'b0, PWM_PERIOD - 64);
        end
        vectors++;
        if (rep_hi.size() != base + 5) begin miscompares++; $display("FAIL steady_count got %0d want 5", rep_hi.size() - base); end
        for (int i = 0; i < 5; i++) begin
            if (base + i < rep_hi.size()) begin
                vectors++;
                if (rep_hi[base+i] != 64 || rep_per[base+i] != 256 || rep_st[base+i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL steady_report[%0d] got hi=%0d per=%0d st=%b want hi=64 per=256 st=0", i, rep_hi[base+i], rep_per[base+i], rep_st[base+i]);
                end
            end
        end
        if (rep_cyc.size() == base + 5) begin
            vectors++;
            if (rep_cyc[base+4] != t + LAT) begin miscompares++; $display("FAIL steady_latency got %0d want %0d", rep_cyc[base+4], t + LAT); end
        end
    endtask

    task automatic test_duty_change();
        int base = rep_hi.size();
        int unsigned exp_hi[4] = '{64, 200, 200, 200};
        for (int k = 0; k < 3; k++) begin
            run(1'b1, 200);
            run(1'b0, 56);
        end
        run(1'b1, 10);
        vectors++;
        if (rep_hi.size() != base + 4) begin miscompares++; $display("FAIL duty_count got %0d want 4", rep_hi.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < rep_hi.size()) begin
                vectors++;
                if (rep_hi[base+i] != exp_hi[i] || rep_per[base+i] != 256) begin
                    miscompares++;
                    $display("FAIL duty_report[%0d] got hi=%0d per=%0d want hi=%0d per=256", i, rep_hi[base+i], rep_per[base+i], exp_hi[i]);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        int base = rep_hi.size();
        run(1'b0, 5);
        for (int k = 0; k < 6; k++) begin
            run(1'b1, 1);
            run(1'b0, 9);
        end
        vectors++;
        if (rep_hi.size() != base + 6) begin miscompares++; $display("FAIL pulse_count got %0d want 6", rep_hi.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (base + i < rep_hi.size()) begin
                vectors++;
                if (rep_hi[base+i] != ((i == 0) ? 10 : 1) || rep_per[base+i] != ((i == 0) ? 15 : 10)) begin
                    miscompares++;
                    $display("FAIL pulse_report[%0d] got hi=%0d per=%0d want hi=%0d per=%0d", i, rep_hi[base+i], rep_per[base+i], (i == 0) ? 10 : 1, (i == 0) ? 15 : 10);
                end
            end
        end
    endtask

    task automatic test_static();
        int base = rep_hi.size();
        int unsigned t = cyc;
        run(1'b1, 4200);
        vectors++;
        if (rep_hi.size() != base + 2) begin miscompares++; $display("FAIL static1_count got %0d want 2", rep_hi.size() - base); end
        if (rep_hi.size() == base + 2) begin
            vectors++;
            if (rep_hi[base] != 1 || rep_per[base] != 10 || rep_st[base] !== 1'b0) begin
                miscompares++; $display("FAIL static1_last_period got hi=%0d per=%0d st=%b want 1 10 0", rep_hi[base], rep_per[base], rep_st[base]);
            end
            vectors++;
            if (rep_hi[base+1] != 0 || rep_per[base+1] != 0 || rep_st[base+1] !== 1'b1 || rep_lvl[base+1] !== 1'b1) begin
                miscompares++; $display("FAIL static1_report got hi=%0d per=%0d st=%b lvl=%b want 0 0 1 1", rep_hi[base+1], rep_per[base+1], rep_st[base+1], rep_lvl[base+1]);
            end
            vectors++;
            if (rep_cyc[base+1] != t + LAT + TIMEOUT) begin miscompares++; $display("FAIL static1_time got %0d want %0d", rep_cyc[base+1], t + LAT + TIMEOUT); end
        end
        base = rep_hi.size();
        t = cyc;
        run(1'b0, 4200);
        run(1'b0, 4200);
        vectors++;
        if (rep_hi.size() != base + 1) begin miscompares++; $display("FAIL static0_count got %0d want 1", rep_hi.size() - base); end
        if (rep_hi.size() == base + 1) begin
            vectors++;
            if (rep_st[base] !== 1'b1 || rep_lvl[base] !== 1'b0 || rep_per[base] != 0) begin
                miscompares++; $display("FAIL static0_report got st=%b lvl=%b per=%0d want 1 0 0", rep_st[base], rep_lvl[base], rep_per[base]);
            end
            vectors++;
            if (rep_cyc[base] != t + LAT + TIMEOUT) begin miscompares++; $display("FAIL static0_time got %0d want %0d", rep_cyc[base], t + LAT + TIMEOUT); end
        end
    endtask

    task automatic test_async_reset();
        int base = rep_hi.size();
        int unsigned t;
        run(1'b1, 30); run(1'b0, 30); run(1'b1, 30); run(1'b0, 10);
        vectors++;
        if (rep_hi.size() != base + 1 || period_cnt !== 16'd60 || high_cnt !== 16'd30) begin
            miscompares++; $display("FAIL prereset_report got n=%0d hi=%0d per=%0d want 1 30 60", rep_hi.size() - base, high_cnt, period_cnt);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (high_cnt !== 16'd0 || period_cnt !== 16'd0 || is_static !== 1'b0 || static_level !== 1'b0 || valid !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_clear got hi=%0d per=%0d st=%b lvl=%b v=%b want all 0", high_cnt, period_cnt, is_static, static_level, valid);
        end
        @(negedge clk);
        #4 rst = 1'b0;
        @(negedge clk);
        base = rep_hi.size();
        run(1'b0, 10); run(1'b1, 30); run(1'b0, 30);
        t = cyc;
        run(1'b1, 30); run(1'b0, 30);
        vectors++;
        if (rep_hi.size() != base + 1) begin miscompares++; $display("FAIL postreset_count got %0d want 1", rep_hi.size() - base); end
        if (rep_hi.size() == base + 1) begin
            vectors++;
            if (rep_hi[base] != 30 || rep_per[base] != 60 || rep_cyc[base] != t + LAT) begin
                miscompares++; $display("FAIL postreset_report got hi=%0d per=%0d cyc=%0d want 30 60 %0d", rep_hi[base], rep_per[base], rep_cyc[base], t + LAT);
            end
        end
    endtask

    task automatic test_enable_gap();
        int base = rep_hi.size();
        int unsigned t;
        run(1'b1, 10);
        enable = 1'b0;
        run(1'b1, 20);
        vectors++;
        if (rep_hi.size() != base + 1 || high_cnt !== 16'd30 || period_cnt !== 16'd60 || valid !== 1'b0) begin
            miscompares++; $display("FAIL disable_hold got n=%0d hi=%0d per=%0d v=%b want 1 30 60 0", rep_hi.size() - base, high_cnt, period_cnt, valid);
        end
        enable = 1'b1;
        base = rep_hi.size();
        run(1'b1, 10); run(1'b0, 20); run(1'b1, 15); run(1'b0, 25);
        t = cyc;
        run(1'b1, 15); run(1'b0, 25); run(1'b1, 5);
        vectors++;
        if (rep_hi.size() != base + 2) begin miscompares++; $display("FAIL reenable_count got %0d want 2", rep_hi.size() - base); end
        if (rep_hi.size() == base + 2) begin
            vectors++;
            if (rep_cyc[base] != t + LAT) begin miscompares++; $display("FAIL reenable_first_time got %0d want %0d", rep_cyc[base], t + LAT); end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (rep_hi[base+i] != 15 || rep_per[base+i] != 40 || rep_st[base+i] !== 1'b0) begin
                    miscompares++; $display("FAIL reenable_report[%0d] got hi=%0d per=%0d st=%b want 15 40 0", i, rep_hi[base+i], rep_per[base+i], rep_st[base+i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_duty_change();
        test_short_pulse();
        test_static();
        test_async_reset();
        test_enable_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
